axis_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI-Stream style datapath (the register buffer `BUFFER`, 4-bit `tdata`) between `N_PORTS` upstream requesters. It locks a grant to one requester for up to `MAX_BURST` accepted beats. It then rotates priority and presents the winner's stream on a single master port that drives `BUFFER`'s `tvalid_i`/`tdata_i` and takes its `tready_o`. The block is stream-transparent (no data storage) and holds all arbitration state in registers.

---
 rtl/axis_rr_arbiter_pkg.sv | 13 +
 rtl/axis_rr_arbiter_if.sv | 31 +++
 rtl/axis_rr_arbiter_rr_picker.sv | 25 ++
 rtl/axis_rr_arbiter.sv | 92 +++++++++
 tb/tb_axis_rr_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared arbitration types and default sizing for round-robin stream schedulers.
package axis_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_N_PORTS   = 4;
    localparam int DEF_DATA_W    = 4;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Requester-side and master-side stream bundle of the round-robin arbiter.
interface axis_rr_arbiter_if
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS = DEF_N_PORTS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = $clog2(N_PORTS)
) ();

    logic [N_PORTS-1:0]        tvalid_i;
    logic [N_PORTS-1:0]        tready_o;
    logic [N_PORTS*DATA_W-1:0] tdata_i;
    logic                      tvalid_o;
    logic                      tready_i;
    logic [DATA_W-1:0]         tdata_o;
    logic [ID_W-1:0]           tid_o;
    logic                      busy_o;

    // Arbiter side
    modport slave (
        input  tvalid_i, tdata_i, tready_i,
        output tready_o, tvalid_o, tdata_o, tid_o, busy_o
    );

    // Environment side: requesters plus the downstream buffer
    modport master (
        output tvalid_i, tdata_i, tready_i,
        input  tready_o, tvalid_o, tdata_o, tid_o, busy_o
    );

endinterface

// File: rtl/axis_rr_arbiter_rr_picker.sv
// Round-robin picker: first asserted request after `last`, wrapping at N_PORTS-1.
// Latency: combinational.
// Backpressure: none; pure function of req and last.
module rr_picker #(
    parameter int N_PORTS = 4,
    parameter int ID_W    = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    always_comb begin
        winner = '0;
        // Scan farthest offset first so the nearest requester after `last` overwrites
        for (int off = N_PORTS; off >= 1; off--) begin
            if (req[ID_W'((int'(last) + off) % N_PORTS)]) begin
                winner = ID_W'((int'(last) + off) % N_PORTS);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter muxing N stream requesters onto one master port, bursts capped at MAX_BURST.
// Latency: 1 cycle from request in IDLE to tvalid_o; data/ready combinational while granted.
// Backpressure: tready_i passes straight to the granted requester; others see tready_o=0.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS   = DEF_N_PORTS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int ID_W      = $clog2(N_PORTS)
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    axis_rr_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_t       state_q;
    logic [ID_W-1:0]  grant_q;
    logic [ID_W-1:0]  last_q;
    logic [CNT_W-1:0] cnt_q;

    logic [ID_W-1:0]    pick_winner;
    logic               pick_any;
    logic               grant_vld;
    logic               hs;
    logic [N_PORTS-1:0] tready_dat;

    rr_picker #(
        .N_PORTS (N_PORTS),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (bus.tvalid_i),
        .last   (last_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    assign grant_vld = (state_q == ST_GRANT) && bus.tvalid_i[grant_q];
    assign hs        = grant_vld && bus.tready_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(N_PORTS - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_winner;
                        cnt_q   <= '0;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Drop the grant only when no beat is pending or the burst quota is used up
                    if (!bus.tvalid_i[grant_q]) begin
                        state_q <= ST_IDLE;
                        last_q  <= grant_q;
                        cnt_q   <= '0;
                    end else if (hs) begin
                        if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                            state_q <= ST_IDLE;
                            last_q  <= grant_q;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tready_dat = '0;
        if (state_q == ST_GRANT) begin
            tready_dat[grant_q] = bus.tready_i;
        end
    end

    assign bus.tready_o = tready_dat;
    assign bus.tvalid_o = grant_vld;
    assign bus.tdata_o  = (state_q == ST_GRANT) ? bus.tdata_i[grant_q*DATA_W +: DATA_W] : '0;
    assign bus.tid_o    = grant_q;
    assign bus.busy_o   = (state_q == ST_GRANT);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboarded random + directed bench for axis_rr_arbiter (N=4, W=4, MAX_BURST=2).
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int MB = 2;

    typedef struct packed {
        logic         tvalid;
        logic [W-1:0] tdata;
        logic [1:0]   tid;
        logic [N-1:0] tready;
        logic         busy;
    } obs_t;

    logic clk_i = 1'b0;
    logic arstn_i = 1'b0;

    axis_rr_arbiter_if #(.N_PORTS(N), .DATA_W(W)) bus ();

    axis_rr_arbiter #(
        .N_PORTS   (N),
        .DATA_W    (W),
        .MAX_BURST (MB)
    ) dut (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    // Stimulus globals
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic           r;
    logic           rn;

    // Reference model: who owns the output port, how many beats it has moved, who went last
    bit m_busy;
    int m_grant;
    int m_last;
    int m_beats;

    obs_t exp_q[$];
    int   hs_tids[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_grant = 0;
        m_last  = N - 1;
        m_beats = 0;
    endtask

    task automatic step();
        obs_t e;
        @(negedge clk_i);
        arstn_i      = rn;
        bus.tvalid_i = v;
        bus.tdata_i  = d;
        bus.tready_i = r;
        if (!rn) model_reset();
        e        = '0;
        e.tid    = 2'(m_grant);
        e.busy   = m_busy;
        if (m_busy) begin
            e.tvalid = v[m_grant];
            e.tdata  = d[m_grant*W +: W];
            e.tready = r ? (N'(1) << m_grant) : '0;
        end
        exp_q.push_back(e);
        if (rn) begin
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (v[(m_last + k) % N]) begin
                        m_grant = (m_last + k) % N;
                        m_busy  = 1'b1;
                        m_beats = 0;
                        break;
                    end
                end
            end else if (!v[m_grant]) begin
                m_busy = 1'b0;
                m_last = m_grant;
            end else if (r) begin
                m_beats++;
                if (m_beats == MB) begin
                    m_busy = 1'b0;
                    m_last = m_grant;
                end
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: samples away from the rising edge and checks against the scoreboard
    initial begin
        obs_t got, want;
        forever begin
            @(negedge clk_i);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got.tvalid = bus.tvalid_o;
                got.tdata  = bus.tdata_o;
                got.tid    = bus.tid_o;
                got.tready = bus.tready_o;
                got.busy   = bus.busy_o;
                n_vec++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL outputs cyc=%0d: got vld=%b dat=%h id=%0d rdy=%b busy=%b, want vld=%b dat=%h id=%0d rdy=%b busy=%b",
                             cyc, got.tvalid, got.tdata, got.tid, got.tready, got.busy,
                             want.tvalid, want.tdata, want.tid, want.tready, want.busy);
                end
                if (bus.tvalid_o && bus.tready_i) hs_tids.push_back(int'(bus.tid_o));
            end
        end
    end

    initial begin
        int exp_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        model_reset();

        // Reset held with random inputs
        rn = 1'b0;
        for (int i = 0; i < 40; i++) begin
            v = N'($urandom); d = (N*W)'($urandom); r = 1'($urandom);
            step();
        end

        // First arbitration after release: port 2, data 1000
        rn = 1'b1; v = 4'b0100; d = '0; d[2*W +: W] = 4'b1000; r = 1'b0;
        steps(2);
        r = 1'b1; step();
        v = '0; steps(3);

        // Backpressure on port 1 for 5 cycles, then accept
        v = 4'b0010; d = '0; d[1*W +: W] = 4'b0001; r = 1'b0;
        steps(6);
        r = 1'b1; step();
        v = '0; steps(2);

        // Burst limit with port 0 continuously valid
        v = 4'b0001; r = 1'b1;
        for (int i = 0; i < 9; i++) begin
            d = (N*W)'($urandom); step();
        end
        v = '0; steps(2);

        // Fairness from a fresh reset: all ports valid
        rn = 1'b0; step();
        rn = 1'b1;
        steps(1);
        hs_tids.delete();
        v = 4'b1111; r = 1'b1;
        for (int i = 0; i < 15; i++) begin
            d = (N*W)'($urandom); step();
        end
        v = '0; step();
        @(negedge clk_i); #3;
        n_vec++;
        if (hs_tids.size() < 9) begin
            n_err++;
            $display("FAIL fairness_count: got %0d handshakes, want at least 9", hs_tids.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (hs_tids[i] != exp_seq[i]) begin
                    n_err++;
                    $display("FAIL fairness_seq[%0d]: got tid %0d, want %0d", i, hs_tids[i], exp_seq[i]);
                end
            end
        end

        // Early release by port 3, pending port 0 wins next (wrap 3 -> 0)
        rn = 1'b0; step();
        rn = 1'b1; r = 1'b1;
        v = 4'b1000; d = (N*W)'($urandom); step();
        v = 4'b1001; d = (N*W)'($urandom); step();
        v = 4'b0001; d = (N*W)'($urandom); steps(3);
        v = '0; steps(2);

        // Async reset mid-burst while tvalid_o is held under backpressure
        v = 4'b0100; d = (N*W)'($urandom); r = 1'b0;
        steps(3);
        rn = 1'b0; steps(3);
        rn = 1'b1; v = 4'b1111; r = 1'b1; steps(4);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            v  = N'($urandom);
            d  = (N*W)'($urandom);
            r  = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 63) != 0);
            step();
        end
        rn = 1'b1; v = '0; steps(2);

        @(negedge clk_i); #4;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
